fifo_uart_tx: RTL and testbench

- Downstream consumer of the 8-bit synchronous FIFO. Pops one byte at a time through the FIFO's read port and serialises it onto a UART-style line: start bit, 8 data bits LSB first, optional even parity, and 1 or 2 stop bits.
- Sits between the FIFO output and the chip-level serial pin.
- Also reports frame completion, a popped-byte count and read-handshake errors.

---
 rtl/fifo_uart_tx_if.sv | 23 ++
 rtl/fifo_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the 8-bit synchronous FIFO and its UART consumer.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic       fifo_valid;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;

  // FIFO side: presents status/data, receives the read request
  modport master (
    output fifo_empty,
    output fifo_valid,
    output fifo_data,
    input  fifo_rd_en
  );

  // Consumer side: issues the read request, receives status/data
  modport slave (
    input  fifo_empty,
    input  fifo_valid,
    input  fifo_data,
    output fifo_rd_en
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one byte per frame and serialises it as
// start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  fifo_uart_tx_if.slave    fifo,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic             rd_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [2:0]         bit_q, bit_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               baud_tc;

  assign baud_tc = (baud_q == BAUD_LAST);

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, bit timing and registered-output precompute
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    par_d   = par_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (en && !fifo.fifo_empty) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fifo.fifo_valid) begin
          shreg_d = fifo.fifo_data;
          par_d   = ^fifo.fifo_data;
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered, so it is decoded from the state being entered
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign fifo.fifo_rd_en = (state_q == S_REQ);
  assign busy            = (state_q != S_IDLE);
  assign tx              = tx_q;
  assign tx_done         = done_q;
  assign rd_err          = err_q;
  assign frame_cnt       = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (8N1, 8E2, 8N1 with 2-bit counter
// at 2 clocks/bit), each fed by a small FIFO model, with a serial-line
// scoreboard that rebuilds every expected frame from the pushed bytes.
module tb_fifo_uart_tx;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  always #5 clk = ~clk;

  int unsigned cpb  [N] = '{4, 4, 2};
  int unsigned par  [N] = '{0, 1, 0};
  int unsigned stp  [N] = '{1, 2, 1};
  logic [15:0] cmask[N] = '{16'hFFFF, 16'hFFFF, 16'h0003};

  fifo_uart_tx_if if_a ();
  fifo_uart_tx_if if_b ();
  fifo_uart_tx_if if_c ();

  logic        tx_a, tx_b, tx_c, busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c, err_a, err_b, err_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo(if_a), .tx(tx_a), .busy(busy_a),
    .tx_done(done_a), .rd_err(err_a), .frame_cnt(cnt_a));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo(if_b), .tx(tx_b), .busy(busy_b),
    .tx_done(done_b), .rd_err(err_b), .frame_cnt(cnt_b));
  fifo_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo(if_c), .tx(tx_c), .busy(busy_c),
    .tx_done(done_c), .rd_err(err_c), .frame_cnt(cnt_c));

  // sampled DUT outputs
  logic        tx_s [N], rd_s [N], busy_s [N], done_s [N], err_s [N];
  logic [15:0] cnt_s [N];
  // FIFO model
  logic [7:0]  fq [N][$];
  logic        valid_s [N];
  logic [7:0]  data_s [N];
  logic        force_inv [N];
  // scoreboard and line monitor
  logic [7:0]  exp_q [N][$];
  logic [11:0] frame_bits [N];
  int          nbits [N], pos [N], hi_run [N], rd_cnt [N], err_cnt [N];
  logic        mon_act [N], pend_done [N], err_due [N], chk_gap [N], saw_frame [N];
  logic [15:0] exp_cnt [N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    tx_s[0] = tx_a;  tx_s[1] = tx_b;  tx_s[2] = tx_c;
    rd_s[0] = if_a.fifo_rd_en; rd_s[1] = if_b.fifo_rd_en; rd_s[2] = if_c.fifo_rd_en;
    busy_s[0] = busy_a; busy_s[1] = busy_b; busy_s[2] = busy_c;
    done_s[0] = done_a; done_s[1] = done_b; done_s[2] = done_c;
    err_s[0] = err_a;  err_s[1] = err_b;  err_s[2] = err_c;
    cnt_s[0] = cnt_a;  cnt_s[1] = cnt_b;  cnt_s[2] = {14'd0, cnt_c};
  endtask

  task automatic drive_inputs();
    if_a.fifo_empty = (fq[0].size() == 0);
    if_a.fifo_valid = valid_s[0];
    if_a.fifo_data  = data_s[0];
    if_b.fifo_empty = (fq[1].size() == 0);
    if_b.fifo_valid = valid_s[1];
    if_b.fifo_data  = data_s[1];
    if_c.fifo_empty = (fq[2].size() == 0);
    if_c.fifo_valid = valid_s[2];
    if_c.fifo_data  = data_s[2];
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic expect_frame);
    fq[i].push_back(b);
    if (expect_frame) exp_q[i].push_back(b);
    drive_inputs();
  endtask

  task automatic monitor(input int i, input logic new_err);
    logic [7:0] b;
    chk($sformatf("tx_done[%0d]", i), done_s[i], pend_done[i]);
    if (pend_done[i]) exp_cnt[i]++;
    pend_done[i] = 1'b0;
    chk($sformatf("rd_err[%0d]", i), err_s[i], err_due[i]);
    if (err_s[i]) err_cnt[i]++;
    err_due[i] = new_err;
    chk($sformatf("frame_cnt[%0d]", i), cnt_s[i], exp_cnt[i] & cmask[i]);
    if (!mon_act[i]) begin
      if (tx_s[i] == 1'b0) begin
        if (exp_q[i].size() == 0) begin
          chk($sformatf("spurious_start[%0d]", i), tx_s[i], 1'b1);
        end else begin
          b = exp_q[i].pop_front();
          frame_bits[i] = '1;
          frame_bits[i][0] = 1'b0;
          for (int k = 0; k < 8; k++) frame_bits[i][1+k] = b[k];
          nbits[i] = 9;
          if (par[i] != 0) begin
            frame_bits[i][9] = ^b;
            nbits[i] = 10;
          end
          nbits[i] += int'(stp[i]);
          if (chk_gap[i] && saw_frame[i]) chk($sformatf("gap[%0d]", i), hi_run[i], 3);
          saw_frame[i] = 1'b1;
          mon_act[i] = 1'b1;
          pos[i] = 0;
        end
      end else begin
        hi_run[i]++;
      end
    end
    if (mon_act[i]) begin
      chk($sformatf("tx_bit[%0d] pos %0d", i, pos[i]), tx_s[i], frame_bits[i][pos[i] / int'(cpb[i])]);
      chk($sformatf("busy[%0d]", i), busy_s[i], 1'b1);
      pos[i]++;
      if (pos[i] == nbits[i] * int'(cpb[i])) begin
        mon_act[i] = 1'b0;
        pend_done[i] = 1'b1;
        hi_run[i] = 0;
      end
    end
  endtask

  task automatic cycle();
    logic rd_p [N];
    logic rst_p;
    rst_p = rst_n;
    for (int i = 0; i < N; i++) rd_p[i] = rd_s[i];
    @(posedge clk);
    #1;
    sample();
    for (int i = 0; i < N; i++) begin
      valid_s[i] = 1'b0;
      if (rd_p[i]) begin
        rd_cnt[i]++;
        chk($sformatf("rd_underflow[%0d]", i), (fq[i].size() != 0), 1'b1);
        if (fq[i].size() != 0) begin
          data_s[i]  = fq[i].pop_front();
          valid_s[i] = !force_inv[i];
        end
      end
      chk($sformatf("rd_single[%0d]", i), rd_p[i] && rd_s[i], 1'b0);
      if (!rst_p) begin
        chk($sformatf("rst_tx[%0d]", i), tx_s[i], 1'b1);
        chk($sformatf("rst_busy[%0d]", i), busy_s[i], 1'b0);
        chk($sformatf("rst_rd[%0d]", i), rd_s[i], 1'b0);
        chk($sformatf("rst_done[%0d]", i), done_s[i], 1'b0);
        chk($sformatf("rst_err[%0d]", i), err_s[i], 1'b0);
        chk($sformatf("rst_cnt[%0d]", i), cnt_s[i], 16'd0);
        mon_act[i] = 1'b0; pend_done[i] = 1'b0; err_due[i] = 1'b0;
        exp_cnt[i] = '0;   saw_frame[i] = 1'b0; hi_run[i] = 0;
      end else begin
        monitor(i, rd_p[i] && force_inv[i]);
      end
    end
    drive_inputs();
  endtask

  task automatic wait_tx_low(input int i, output int n);
    n = 0;
    while (tx_s[i] !== 1'b0 && n < 200) begin
      cycle();
      n++;
    end
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    while (done_s[i] !== 1'b1 && n < 400) begin
      cycle();
      n++;
    end
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while ((mon_act[i] || pend_done[i] || busy_s[i] || exp_q[i].size() != 0 ||
            fq[i].size() != 0) && n < 1000) begin
      cycle();
      n++;
    end
    chk($sformatf("drain_timeout[%0d]", i), (n < 1000), 1'b1);
  endtask

  task automatic send_check(input int i, input logic [7:0] b, input int len);
    int n;
    push(i, b, 1'b1);
    wait_tx_low(i, n);
    chk($sformatf("latency[%0d] %02h", i, b), n, 3);
    wait_done(i, n);
    chk($sformatf("frame_len[%0d] %02h", i, b), n, len);
    cycle();
  endtask

  initial begin
    int n, r0, e0;
    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < N; i++) begin
      valid_s[i] = 1'b0; data_s[i] = '0; force_inv[i] = 1'b0;
      mon_act[i] = 1'b0; pend_done[i] = 1'b0; err_due[i] = 1'b0;
      chk_gap[i] = 1'b0; saw_frame[i] = 1'b0; exp_cnt[i] = '0;
      pos[i] = 0; nbits[i] = 0; hi_run[i] = 0; rd_cnt[i] = 0; err_cnt[i] = 0;
      frame_bits[i] = '1;
    end
    sample();
    drive_inputs();

    // reset held with data waiting: no read until release
    push(0, 8'h5A, 1'b1);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    chk("rd_after_reset", rd_s[0], 1'b1);
    wait_idle(0);

    // 8N1 single byte, 40-cycle frame
    send_check(0, 8'hA5, 40);
    chk("cnt_after_a5", cnt_s[0], 16'd2);

    // 8E2: parity 1 then parity 0, 48-cycle frames
    send_check(1, 8'h07, 48);
    send_check(1, 8'h03, 48);
    chk("cnt_b", cnt_s[1], 16'd2);

    // three queued bytes back to back
    chk_gap[0] = 1'b1;
    saw_frame[0] = 1'b0;
    r0 = rd_cnt[0];
    push(0, 8'h01, 1'b1);
    push(0, 8'h80, 1'b1);
    push(0, 8'hFF, 1'b1);
    wait_idle(0);
    chk("rd_pulses_3", rd_cnt[0] - r0, 3);
    chk("cnt_after_3", cnt_s[0], 16'd5);
    chk_gap[0] = 1'b0;

    // broken handshake: valid withheld in WAIT
    force_inv[0] = 1'b1;
    e0 = err_cnt[0];
    push(0, 8'h55, 1'b0);
    repeat (8) cycle();
    force_inv[0] = 1'b0;
    chk("rd_err_pulses", err_cnt[0] - e0, 1);
    chk("err_tx_idle", tx_s[0], 1'b1);
    chk("err_busy", busy_s[0], 1'b0);
    chk("err_cnt_kept", cnt_s[0], 16'd5);

    // reset during data bit 3 of 8'hF0, then 8'h3C goes out whole
    push(0, 8'hF0, 1'b1);
    push(0, 8'h3C, 1'b1);
    wait_tx_low(0, n);
    chk("latency_f0", n, 3);
    repeat (17) cycle();
    chk("mid_bit3", tx_s[0], 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("abort_tx", tx_s[0], 1'b1);
    chk("abort_busy", busy_s[0], 1'b0);
    wait_idle(0);
    chk("cnt_after_abort", cnt_s[0], 16'd1);

    // 2-bit counter wrap, 2 clocks per bit
    chk_gap[2] = 1'b1;
    saw_frame[2] = 1'b0;
    push(2, 8'h11, 1'b1);
    push(2, 8'h22, 1'b1);
    push(2, 8'h33, 1'b1);
    push(2, 8'h44, 1'b1);
    push(2, 8'h55, 1'b1);
    wait_idle(2);
    chk("cnt_wrap", cnt_s[2], 16'd1);
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
